cc_miss_req_unit: RTL and testbench
===================================

# cc_miss_req_unit

Issues the AXI read-address request for every cache miss and records the miss address for the refill path. Sits between the tag-compare stage and the AXI AR channel. Pushes each accepted miss address into the miss-address FIFO, which the data-fill unit pops on the first returning beat. Tracks outstanding bursts and back-pressures the pipeline when the limit is reached.

## Interface
- MAX_OUTSTANDING, 4: maximum AR bursts issued but not yet completed by rlast.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- miss_i  in  1  miss request from tag compare.
- miss_addr_i  in  32  byte address of the missing access.
- miss_req_ready_o  out  1  block can accept a miss this cycle.
- mem_arvalid_o  out  1  AXI AR valid.
- mem_arready_i  in  1  AXI AR ready.
- mem_araddr_o  out  32  AR address, 8-byte aligned.
- mem_arlen_o  out  4  constant 7 (8 beats).
- mem_arsize_o  out  3  constant 3 (8 bytes per beat).
- mem_arburst_o  out  2  constant 2'b10 (WRAP).
- mem_rvalid_i  in  1  AXI R valid, monitored only.
- mem_rready_i  in  1  AXI R ready, monitored only.
- mem_rlast_i  in  1  AXI R last, monitored only.
- miss_addr_fifo_full_i  in  1  miss-address FIFO full.
- miss_addr_fifo_wren_o  out  1  FIFO push strobe, one cycle per miss.
- miss_addr_fifo_wdata_o  out  32  miss address, unmodified.

## Operation
- States: IDLE, ISSUE.
- IDLE
  - miss_req_ready_o = (outstanding < MAX_OUTSTANDING) & !miss_addr_fifo_full_i.
  - When miss_i & ready: latch miss_addr_i, clear ar_done and push_done, go to ISSUE.
- ISSUE
  - miss_req_ready_o = 0.
  - mem_arvalid_o = !ar_done.
  - mem_araddr_o = {latched[31:3], 3'b000}, giving critical-word-first wrap.
  - miss_addr_fifo_wren_o = !push_done & !miss_addr_fifo_full_i.
  - miss_addr_fifo_wdata_o = latched address.
  - ar_done sets on arvalid & arready; push_done sets on wren.
  - Return to IDLE in the cycle after both are done. Both may complete in the same cycle.
- Outstanding counter
  - Width $clog2(MAX_OUTSTANDING+1).
  - +1 on the AR handshake; −1 on rvalid & rready & rlast.
  - Both in the same cycle: unchanged.
  - A decrement at 0 is ignored (saturates); it never wraps.
- AXI rules
  - mem_arvalid_o never depends on mem_arready_i.
  - Once arvalid is asserted, it and mem_araddr_o stay stable until the handshake.
- miss_i while not ready is ignored; the upstream stage holds it.
- FIFO order equals AR issue order: one miss is in flight at a time.

## Timing
- Reset values:
  - State IDLE, counter 0, ar_done = push_done = 0, latched address 0.
  - mem_arvalid_o = 0, miss_addr_fifo_wren_o = 0, mem_araddr_o = 0, miss_addr_fifo_wdata_o = 0.
  - miss_req_ready_o = !miss_addr_fifo_full_i.
  - AR constants are driven throughout reset.
- Miss accepted in cycle N: arvalid and wren high in N+1.
  - If arready is high in N+1: counter increments at the N+1 edge, IDLE in N+2, ready again in N+2.
  - Peak throughput: one miss per 2 cycles.
- FIFO full during ISSUE: wren is held off and the AR may still complete; stay in ISSUE until the push happens.
- rst asserted mid-ISSUE: abandon the request and apply all reset values next cycle. Memory-side cleanup is the system's responsibility.

## Structure
- Shared package cc_pkg holds:
  - AXI burst enum (FIXED/INCR/WRAP).
  - CC_ARLEN = 4'd7, CC_ARSIZE = 3'd3.
  - Line size constant (64 B).
  - State enum for this block.
- One sub-module: cc_outstanding_cnt, a parameterised saturating up/down counter with inc, dec and count outputs.

## Test plan
- Single miss, addr 0x0001_2348, arready already high.
  - Next cycle: araddr 0x0001_2348, arlen 7, arsize 3, arburst 2'b10.
  - FIFO wdata 0x0001_2348 with a one-cycle wren.
  - Counter reaches 1; ready returns 2 cycles after acceptance.
- arready low for 5 cycles.
  - arvalid held with a stable address for all 5 cycles.
  - Exactly one wren pulse.
  - IDLE the cycle after the handshake.
- Four back-to-back misses with no R traffic.
  - Counter reaches 4; ready deasserts.
  - One rlast beat (rvalid & rready): counter 3, ready reasserts next cycle.
- FIFO full at acceptance-plus-1 for 3 cycles while arready is high.
  - AR completes first; wren fires when full drops; no duplicate AR.
- AR handshake and rlast in the same cycle at count 2: count stays 2.
- rst pulsed while arvalid is high: next cycle arvalid = 0, wren = 0, count = 0, state IDLE.

Source files
------------

// File: rtl/cc_pkg.sv
// Shared cache-controller definitions: AXI burst encoding, fixed AR burst
// shape for a line refill, and the miss-request unit state type.
package cc_pkg;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'b00,
    AXI_BURST_INCR  = 2'b01,
    AXI_BURST_WRAP  = 2'b10
  } axi_burst_e;

  // A 64-byte line is refilled as 8 beats of 8 bytes.
  localparam int unsigned CC_LINE_BYTES = 64;
  localparam logic [3:0]  CC_ARLEN      = 4'd7;
  localparam logic [2:0]  CC_ARSIZE     = 3'd3;

  typedef enum logic {
    MRQ_IDLE,
    MRQ_ISSUE
  } mrq_state_e;

  // Beat-align a byte address; the WRAP burst then returns the critical word first.
  function automatic logic [31:0] cc_beat_align(input logic [31:0] addr);
    return {addr[31:3], 3'b000};
  endfunction

endpackage

// File: rtl/cc_outstanding_cnt.sv
// Saturating up/down counter of AR bursts issued but not yet ended by rlast.
module cc_outstanding_cnt #(
  parameter int unsigned MAX_COUNT = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               inc_i,
  input  logic                               dec_i,
  output logic [$clog2(MAX_COUNT+1)-1:0]     count_o
);

  localparam int unsigned W = $clog2(MAX_COUNT + 1);

  logic [W-1:0] count_q, count_d;

  // Next count: simultaneous inc/dec cancel; both ends saturate.
  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_i && (count_q != W'(MAX_COUNT))) begin
      count_d = count_q + W'(1);
    end else if (dec_i && !inc_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/cc_miss_req_unit.sv
// Turns each accepted cache miss into one AXI AR line-refill burst and one
// push into the miss-address FIFO; one miss is in flight at a time, so FIFO
// order always matches AR issue order.
module cc_miss_req_unit
  import cc_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        miss_i,
  input  logic [31:0] miss_addr_i,
  output logic        miss_req_ready_o,
  output logic        mem_arvalid_o,
  input  logic        mem_arready_i,
  output logic [31:0] mem_araddr_o,
  output logic [3:0]  mem_arlen_o,
  output logic [2:0]  mem_arsize_o,
  output logic [1:0]  mem_arburst_o,
  input  logic        mem_rvalid_i,
  input  logic        mem_rready_i,
  input  logic        mem_rlast_i,
  input  logic        miss_addr_fifo_full_i,
  output logic        miss_addr_fifo_wren_o,
  output logic [31:0] miss_addr_fifo_wdata_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  mrq_state_e  state_q;
  logic [31:0] addr_q;
  logic        ar_done_q;
  logic        push_done_q;
  logic [CNT_W-1:0] outstanding;

  logic ar_hs;
  logic burst_end;

  // Outputs depend only on registered state plus the FIFO-full input, so
  // arvalid never looks at arready and stays put until its handshake.
  always_comb begin
    miss_req_ready_o      = (state_q == MRQ_IDLE) &&
                            (outstanding < CNT_W'(MAX_OUTSTANDING)) &&
                            !miss_addr_fifo_full_i;
    mem_arvalid_o         = (state_q == MRQ_ISSUE) && !ar_done_q;
    miss_addr_fifo_wren_o = (state_q == MRQ_ISSUE) && !push_done_q &&
                            !miss_addr_fifo_full_i;
  end

  assign mem_araddr_o           = cc_beat_align(addr_q);
  assign miss_addr_fifo_wdata_o = addr_q;
  assign mem_arlen_o            = CC_ARLEN;
  assign mem_arsize_o           = CC_ARSIZE;
  assign mem_arburst_o          = AXI_BURST_WRAP;

  assign ar_hs     = mem_arvalid_o && mem_arready_i;
  assign burst_end = mem_rvalid_i && mem_rready_i && mem_rlast_i;

  // Miss FSM: latch in IDLE, then wait in ISSUE until both the AR handshake
  // and the FIFO push have happened (in either order or together).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= MRQ_IDLE;
      addr_q      <= '0;
      ar_done_q   <= 1'b0;
      push_done_q <= 1'b0;
    end else begin
      unique case (state_q)
        MRQ_IDLE: begin
          if (miss_i && miss_req_ready_o) begin
            addr_q      <= miss_addr_i;
            ar_done_q   <= 1'b0;
            push_done_q <= 1'b0;
            state_q     <= MRQ_ISSUE;
          end
        end
        MRQ_ISSUE: begin
          if (ar_hs)                 ar_done_q   <= 1'b1;
          if (miss_addr_fifo_wren_o) push_done_q <= 1'b1;
          if ((ar_done_q || ar_hs) && (push_done_q || miss_addr_fifo_wren_o)) begin
            state_q <= MRQ_IDLE;
          end
        end
        default: state_q <= MRQ_IDLE;
      endcase
    end
  end

  cc_outstanding_cnt #(
    .MAX_COUNT (MAX_OUTSTANDING)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (ar_hs),
    .dec_i   (burst_end),
    .count_o (outstanding)
  );

endmodule

// File: tb/tb_cc_miss_req_unit.sv
// Testbench for cc_miss_req_unit: directed vector table, hand sequences for
// multi-cycle corners, and random traffic against a transaction-level model.
module tb_cc_miss_req_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_i;
  logic [31:0] miss_addr_i;
  logic        miss_req_ready_o;
  logic        mem_arvalid_o;
  logic        mem_arready_i;
  logic [31:0] mem_araddr_o;
  logic [3:0]  mem_arlen_o;
  logic [2:0]  mem_arsize_o;
  logic [1:0]  mem_arburst_o;
  logic        mem_rvalid_i;
  logic        mem_rready_i;
  logic        mem_rlast_i;
  logic        miss_addr_fifo_full_i;
  logic        miss_addr_fifo_wren_o;
  logic [31:0] miss_addr_fifo_wdata_o;

  always #5 clk = ~clk;

  cc_miss_req_unit #(.MAX_OUTSTANDING(4)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .miss_i                 (miss_i),
    .miss_addr_i            (miss_addr_i),
    .miss_req_ready_o       (miss_req_ready_o),
    .mem_arvalid_o          (mem_arvalid_o),
    .mem_arready_i          (mem_arready_i),
    .mem_araddr_o           (mem_araddr_o),
    .mem_arlen_o            (mem_arlen_o),
    .mem_arsize_o           (mem_arsize_o),
    .mem_arburst_o          (mem_arburst_o),
    .mem_rvalid_i           (mem_rvalid_i),
    .mem_rready_i           (mem_rready_i),
    .mem_rlast_i            (mem_rlast_i),
    .miss_addr_fifo_full_i  (miss_addr_fifo_full_i),
    .miss_addr_fifo_wren_o  (miss_addr_fifo_wren_o),
    .miss_addr_fifo_wdata_o (miss_addr_fifo_wdata_o)
  );

  int vectors = 0;
  int miscompares = 0;

  // Transaction-level model: at most one pending miss with two outstanding
  // obligations (AR and FIFO push), plus a count of bursts in flight.
  bit          m_busy, m_need_ar, m_need_push;
  logic [31:0] m_addr;
  int          m_outst;

  // Values observed at the last sample point.
  logic        s_ready, s_arv, s_wren;
  logic [31:0] s_araddr, s_wdata;
  logic [2:0]  s_cnt;

  typedef struct {
    bit rst; bit miss; logic [31:0] addr; bit arready; bit full; bit rbeat;
    bit e_ready; bit e_arv; bit e_wren;
    logic [31:0] e_araddr; logic [31:0] e_wdata; int e_cnt;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drv(input bit r, input bit m, input logic [31:0] a, input bit ar,
                     input bit f, input bit rv, input bit rr, input bit rl);
    rst = r; miss_i = m; miss_addr_i = a; mem_arready_i = ar;
    miss_addr_fifo_full_i = f; mem_rvalid_i = rv; mem_rready_i = rr; mem_rlast_i = rl;
  endtask

  task automatic model_reset();
    m_busy = 0; m_need_ar = 0; m_need_push = 0; m_addr = '0; m_outst = 0;
  endtask

  // One cycle: entered 1 ns after a rising edge with inputs already driven.
  task automatic tick();
    bit e_ready, e_arv, e_wren, ar_hs, rl_beat;
    e_ready = !m_busy && (m_outst < 4) && !miss_addr_fifo_full_i;
    e_arv   = m_busy && m_need_ar;
    e_wren  = m_busy && m_need_push && !miss_addr_fifo_full_i;
    #4;
    s_ready = miss_req_ready_o; s_arv = mem_arvalid_o; s_wren = miss_addr_fifo_wren_o;
    s_araddr = mem_araddr_o; s_wdata = miss_addr_fifo_wdata_o; s_cnt = dut.u_cnt.count_o;
    chk("ready", {31'd0, s_ready}, {31'd0, e_ready});
    chk("arvalid", {31'd0, s_arv}, {31'd0, e_arv});
    chk("wren", {31'd0, s_wren}, {31'd0, e_wren});
    chk("outstanding", {29'd0, s_cnt}, m_outst);
    chk("ar_consts", {23'd0, mem_arlen_o, mem_arsize_o, mem_arburst_o}, {23'd0, 4'd7, 3'd3, 2'b10});
    if (m_busy) begin
      chk("araddr", s_araddr, m_addr & 32'hFFFF_FFF8);
      chk("wdata", s_wdata, m_addr);
    end
    @(posedge clk);
    ar_hs   = e_arv && mem_arready_i;
    rl_beat = mem_rvalid_i && mem_rready_i && mem_rlast_i;
    if (rst) begin
      model_reset();
    end else begin
      if (!m_busy) begin
        if (miss_i && e_ready) begin
          m_busy = 1; m_need_ar = 1; m_need_push = 1; m_addr = miss_addr_i;
        end
      end else begin
        if (ar_hs)  m_need_ar = 0;
        if (e_wren) m_need_push = 0;
        if (!m_need_ar && !m_need_push) m_busy = 0;
      end
      if (ar_hs && !rl_beat && m_outst < 4) m_outst++;
      else if (rl_beat && !ar_hs && m_outst > 0) m_outst--;
    end
    #1;
  endtask

  task automatic do_reset();
    drv(1, 0, '0, 0, 0, 0, 0, 0); tick();
    drv(0, 0, '0, 0, 0, 0, 0, 0);
  endtask

  int wren_pulses, ar_pulses;

  initial begin
    drv(1, 0, '0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    model_reset();

    // rst miss addr ar full rb | ready arv wren araddr wdata cnt
    tbl[0] = '{1, 0, 32'h0,         0, 0, 0, 1, 0, 0, 32'h0,         32'h0,         0};
    tbl[1] = '{1, 0, 32'h0,         0, 1, 0, 0, 0, 0, 32'h0,         32'h0,         0};
    tbl[2] = '{0, 1, 32'h0001_2348, 1, 0, 0, 1, 0, 0, 32'h0,         32'h0,         0};
    tbl[3] = '{0, 0, 32'h0,         1, 0, 0, 0, 1, 1, 32'h0001_2348, 32'h0001_2348, 0};
    tbl[4] = '{0, 0, 32'h0,         1, 0, 0, 1, 0, 0, 32'h0001_2348, 32'h0001_2348, 1};
    tbl[5] = '{0, 1, 32'h0000_ABCF, 0, 0, 0, 1, 0, 0, 32'h0001_2348, 32'h0001_2348, 1};
    tbl[6] = '{0, 0, 32'h0,         0, 0, 0, 0, 1, 1, 32'h0000_ABC8, 32'h0000_ABCF, 1};
    tbl[7] = '{0, 0, 32'h0,         0, 0, 0, 0, 1, 0, 32'h0000_ABC8, 32'h0000_ABCF, 1};
    tbl[8] = '{0, 0, 32'h0,         1, 0, 0, 0, 1, 0, 32'h0000_ABC8, 32'h0000_ABCF, 1};
    tbl[9] = '{0, 0, 32'h0,         0, 0, 0, 1, 0, 0, 32'h0000_ABC8, 32'h0000_ABCF, 2};
    for (int i = 0; i < 10; i++) begin
      drv(tbl[i].rst, tbl[i].miss, tbl[i].addr, tbl[i].arready, tbl[i].full,
          tbl[i].rbeat, tbl[i].rbeat, tbl[i].rbeat);
      tick();
      chk("tbl_ready", {31'd0, s_ready}, {31'd0, tbl[i].e_ready});
      chk("tbl_arvalid", {31'd0, s_arv}, {31'd0, tbl[i].e_arv});
      chk("tbl_wren", {31'd0, s_wren}, {31'd0, tbl[i].e_wren});
      chk("tbl_araddr", s_araddr, tbl[i].e_araddr);
      chk("tbl_wdata", s_wdata, tbl[i].e_wdata);
      chk("tbl_cnt", {29'd0, s_cnt}, tbl[i].e_cnt);
    end

    // arready held low for 5 cycles
    do_reset();
    drv(0, 1, 32'h8000_0017, 0, 0, 0, 0, 0); tick();
    wren_pulses = 0;
    for (int i = 0; i < 5; i++) begin
      drv(0, 0, '0, 0, 0, 0, 0, 0); tick();
      chk("stall_arvalid", {31'd0, s_arv}, 32'd1);
      chk("stall_araddr", s_araddr, 32'h8000_0010);
      wren_pulses += int'(s_wren);
    end
    drv(0, 0, '0, 1, 0, 0, 0, 0); tick();
    wren_pulses += int'(s_wren);
    drv(0, 0, '0, 0, 0, 0, 0, 0); tick();
    chk("stall_idle_ready", {31'd0, s_ready}, 32'd1);
    chk("stall_idle_arvalid", {31'd0, s_arv}, 32'd0);
    chk("stall_wren_pulses", wren_pulses, 32'd1);

    // Four back-to-back misses, then one rlast beat
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drv(0, 1, 32'h1000 + 32'(i * 64), 1, 0, 0, 0, 0); tick();
      chk("b2b_accept", {31'd0, s_ready}, 32'd1);
      drv(0, 0, '0, 1, 0, 0, 0, 0); tick();
    end
    drv(0, 1, 32'h2000, 1, 0, 0, 0, 0); tick();
    chk("b2b_full_cnt", {29'd0, s_cnt}, 32'd4);
    chk("b2b_not_ready", {31'd0, s_ready}, 32'd0);
    drv(0, 0, '0, 0, 0, 1, 1, 1); tick();
    drv(0, 0, '0, 0, 0, 0, 0, 0); tick();
    chk("b2b_after_rlast_cnt", {29'd0, s_cnt}, 32'd3);
    chk("b2b_ready_again", {31'd0, s_ready}, 32'd1);

    // FIFO full for 3 cycles after acceptance while arready is high
    do_reset();
    drv(0, 1, 32'h0000_4444, 1, 0, 0, 0, 0); tick();
    ar_pulses = 0; wren_pulses = 0;
    for (int i = 0; i < 3; i++) begin
      drv(0, 0, '0, 1, 1, 0, 0, 0); tick();
      ar_pulses += int'(s_arv); wren_pulses += int'(s_wren);
    end
    drv(0, 0, '0, 1, 0, 0, 0, 0); tick();
    chk("full_late_wren", {31'd0, s_wren}, 32'd1);
    ar_pulses += int'(s_arv); wren_pulses += int'(s_wren);
    drv(0, 0, '0, 1, 0, 0, 0, 0); tick();
    chk("full_ar_once", ar_pulses, 32'd1);
    chk("full_wren_once", wren_pulses, 32'd1);
    chk("full_back_idle", {31'd0, s_ready}, 32'd1);

    // AR handshake and rlast in the same cycle at count 2
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drv(0, 1, 32'h3000, 1, 0, 0, 0, 0); tick();
      drv(0, 0, '0, 1, 0, 0, 0, 0); tick();
    end
    drv(0, 1, 32'h3040, 0, 0, 0, 0, 0); tick();
    chk("simul_cnt_before", {29'd0, s_cnt}, 32'd2);
    drv(0, 0, '0, 1, 0, 1, 1, 1); tick();
    drv(0, 0, '0, 0, 0, 0, 0, 0); tick();
    chk("simul_cnt_after", {29'd0, s_cnt}, 32'd2);

    // Reset while arvalid is high, then rlast with nothing outstanding
    do_reset();
    drv(0, 1, 32'h5558, 0, 0, 0, 0, 0); tick();
    drv(0, 0, '0, 0, 0, 0, 0, 0); tick();
    chk("rst_pre_arvalid", {31'd0, s_arv}, 32'd1);
    drv(1, 0, '0, 0, 0, 0, 0, 0); tick();
    drv(0, 0, '0, 0, 0, 1, 1, 1); tick();
    chk("rst_arvalid", {31'd0, s_arv}, 32'd0);
    chk("rst_wren", {31'd0, s_wren}, 32'd0);
    chk("rst_cnt", {29'd0, s_cnt}, 32'd0);
    chk("rst_idle", {31'd0, s_ready}, 32'd1);
    drv(0, 0, '0, 0, 0, 0, 0, 0); tick();
    chk("sat_zero_cnt", {29'd0, s_cnt}, 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      drv(($urandom_range(0, 99) == 0), $urandom_range(0, 1) == 1, $urandom,
          $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
          $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
